// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared types and constants for the 5-stage core's hazard control.
//   - REG_AW      : register-address width used for rs/rt/rd fields
//   - hz_state_t  : sequencer states (RUN, MEM_WAIT, HALT)
//   - hz_ctrl_t   : bundle of pipeline enable/flush/freeze controls
//   - CTRL_*      : canonical control patterns; CTRL_BUBBLE is the pattern
//                   driven while reset is high (every register turned into
//                   a NOP, nothing advances)
// -----------------------------------------------------------------------------
package core_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_MEM_WAIT = 2'd1,
      HZ_HALT     = 2'd2
   } hz_state_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_hold;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic mem_freeze;
   } hz_ctrl_t;

   // Reset pattern: nothing advances, every control register becomes a bubble.
   localparam hz_ctrl_t CTRL_BUBBLE = '{
      pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_hold: 1'b0,
      id_ex_flush: 1'b1, ex_mem_flush: 1'b1, mem_freeze: 1'b0};

   // Normal flow: fetch advances, nothing flushed or held.
   localparam hz_ctrl_t CTRL_RUN = '{
      pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_hold: 1'b0,
      id_ex_flush: 1'b0, ex_mem_flush: 1'b0, mem_freeze: 1'b0};

   // Data-memory wait: whole pipe frozen, no state lost.
   localparam hz_ctrl_t CTRL_FREEZE = '{
      pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_hold: 1'b1,
      id_ex_flush: 1'b0, ex_mem_flush: 1'b0, mem_freeze: 1'b1};

   // Taken branch resolved in MEM: load target, squash the three younger instrs.
   localparam hz_ctrl_t CTRL_BRANCH = '{
      pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_hold: 1'b0,
      id_ex_flush: 1'b1, ex_mem_flush: 1'b1, mem_freeze: 1'b0};

   // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
   localparam hz_ctrl_t CTRL_STALL = '{
      pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_hold: 1'b0,
      id_ex_flush: 1'b1, ex_mem_flush: 1'b0, mem_freeze: 1'b0};

endpackage

// File: rtl/hazard_ctrl_unit_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
//   Counts consecutive data-memory busy cycles for the hazard sequencer.
//   Ports:
//     clk, reset  : core clock, async active-high reset (count -> 0)
//     i_clr       : clear the count; with i_inc also high the count loads 1
//                   (first busy cycle seen from RUN)
//     i_inc       : increment the count
//     o_tc        : terminal count, high while count == MEM_TIMEOUT-1
// -----------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMR_W       = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_tc
);

   logic [TMR_W-1:0] r_wt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wt <= '0;
      end else if (i_clr) begin
         r_wt <= i_inc ? TMR_W'(1) : '0;
      end else if (i_inc) begin
         r_wt <= r_wt + TMR_W'(1);
      end
   end

   assign o_tc = (r_wt == TMR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//   Pipeline sequencer for the 5-stage core. Detects load-use hazards, taken
//   branches (resolved in MEM) and data-memory wait states, and drives the
//   PC / IF/ID / ID/EX / EX/MEM enable and flush controls. A small FSM
//   (RUN, MEM_WAIT, HALT) freezes the pipe during memory waits and latches a
//   sticky timeout error after MEM_TIMEOUT consecutive busy cycles.
//
//   Optional feature macro: HAZARD_PERF_EN adds saturating perf counters
//   lu_stall_cnt, br_flush_cnt, wait_cnt (PERF_W bits each).
//
//   Ports:
//     clk, reset            core clock, async active-high reset
//     id_rs, id_rt          source registers of the instruction in ID
//     id_uses_rt            ID instruction reads rt
//     ex_mem_read, ex_rt    load in EX and its destination register
//     mem_branch            taken branch resolved in MEM
//     mem_busy              data memory not ready this cycle
//     pc_write              PC update enable
//     if_id_write           IF/ID enable
//     if_id_flush           IF/ID -> NOP
//     id_ex_hold            ID/EX keeps contents
//     id_ex_flush           zero ID/EX control (bubble)
//     ex_mem_flush          zero EX/MEM control
//     mem_freeze            hold EX/MEM and MEM/WB
//     timeout_err           sticky memory-timeout flag
//     dbg_state             current sequencer state (hz_state_t encoding)
//
//   Handshake note: there is no valid/ready pair here; every control output
//   is a same-cycle combinational function of the registered state and the
//   current inputs, and the consuming pipeline registers sample it on the
//   next posedge clk.
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
   parameter int REG_AW      = core_pkg::REG_AW,
   parameter int MEM_TIMEOUT = 16,
   parameter int TMR_W       = 5,
   parameter int PERF_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              mem_branch,
   input  logic              mem_busy,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_hold,
   output logic              id_ex_flush,
   output logic              ex_mem_flush,
   output logic              mem_freeze,
   output logic              timeout_err,
   output logic [1:0]        dbg_state
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] lu_stall_cnt,
   output logic [PERF_W-1:0] br_flush_cnt,
   output logic [PERF_W-1:0] wait_cnt
`endif
);

   import core_pkg::*;

   localparam logic [1:0] ST_RUN      = HZ_RUN;
   localparam logic [1:0] ST_MEM_WAIT = HZ_MEM_WAIT;
   localparam logic [1:0] ST_HALT     = HZ_HALT;

   // Elaboration-time parameter sanity: the timer must count up to
   // MEM_TIMEOUT without wrapping, and a timeout below 2 is meaningless
   // because the first busy cycle is always spent in RUN.
   if (MEM_TIMEOUT < 2 || (2 ** TMR_W) <= MEM_TIMEOUT || PERF_W < 1) begin : g_bad_cfg
      $error("hazard_ctrl_unit: invalid MEM_TIMEOUT/TMR_W/PERF_W");
   end

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       r_timeout_err;
   logic       w_err_set;
   logic       w_tmr_clr;
   logic       w_tmr_inc;
   logic       w_tmr_tc;
   logic       w_load_use;
   logic       w_freeze;
   logic       w_branch_flush;
   logic       w_lu_stall;
   hz_ctrl_t   w_ctrl;

   // ------------------------------------------------------------------
   // Hazard detection. r0 is hardwired zero, so a load to r0 never
   // creates a dependency.
   // ------------------------------------------------------------------
   assign w_load_use = ex_mem_read & (ex_rt != '0) &
                       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

   // Freeze wins over everything. In MEM_WAIT with mem_busy low the unit
   // behaves exactly like RUN, so branch/load-use pending at release are
   // serviced in that same cycle.
   assign w_freeze       = (r_state == ST_HALT) | mem_busy;
   assign w_branch_flush = ~w_freeze & mem_branch;
   assign w_lu_stall     = ~w_freeze & ~mem_branch & w_load_use;

   // ------------------------------------------------------------------
   // Next-state and timer control.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_tmr_clr   = 1'b0;
      w_tmr_inc   = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (mem_busy) begin
               // First busy cycle: the timer loads 1.
               w_state_nxt = ST_MEM_WAIT;
               w_tmr_clr   = 1'b1;
               w_tmr_inc   = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_busy) begin
               w_tmr_inc = 1'b1;
               if (w_tmr_tc) begin
                  w_state_nxt = ST_HALT;
                  w_err_set   = 1'b1;
               end
            end else begin
               w_state_nxt = ST_RUN;
               w_tmr_clr   = 1'b1;
            end
         end
         ST_HALT: begin
            // Only reset leaves HALT.
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_tmr_clr   = 1'b1;
         end
      endcase
   end

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .TMR_W      (TMR_W)
   ) u_mem_wait_timer (
      .clk  (clk),
      .reset(reset),
      .i_clr(w_tmr_clr),
      .i_inc(w_tmr_inc),
      .o_tc (w_tmr_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_RUN;
         r_timeout_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_err_set) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output decode. Reset is folded in combinationally so the bubble
   // pattern appears as soon as reset rises, without waiting for a clock.
   // ------------------------------------------------------------------
   always_comb begin
      w_ctrl = CTRL_RUN;
      if (reset) begin
         w_ctrl = CTRL_BUBBLE;
      end else if (w_freeze) begin
         w_ctrl = CTRL_FREEZE;
      end else if (w_branch_flush) begin
         w_ctrl = CTRL_BRANCH;
      end else if (w_lu_stall) begin
         w_ctrl = CTRL_STALL;
      end
   end

   assign pc_write     = w_ctrl.pc_write;
   assign if_id_write  = w_ctrl.if_id_write;
   assign if_id_flush  = w_ctrl.if_id_flush;
   assign id_ex_hold   = w_ctrl.id_ex_hold;
   assign id_ex_flush  = w_ctrl.id_ex_flush;
   assign ex_mem_flush = w_ctrl.ex_mem_flush;
   assign mem_freeze   = w_ctrl.mem_freeze;
   assign timeout_err  = r_timeout_err;
   assign dbg_state    = r_state;

`ifdef HAZARD_PERF_EN
   // ------------------------------------------------------------------
   // Saturating event counters; they stop at all-ones rather than wrap.
   // ------------------------------------------------------------------
   logic [PERF_W-1:0] r_lu_stall_cnt;
   logic [PERF_W-1:0] r_br_flush_cnt;
   logic [PERF_W-1:0] r_wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lu_stall_cnt <= '0;
         r_br_flush_cnt <= '0;
         r_wait_cnt     <= '0;
      end else begin
         if (w_lu_stall && (r_lu_stall_cnt != '1)) begin
            r_lu_stall_cnt <= r_lu_stall_cnt + PERF_W'(1);
         end
         if (w_branch_flush && (r_br_flush_cnt != '1)) begin
            r_br_flush_cnt <= r_br_flush_cnt + PERF_W'(1);
         end
         if (w_freeze && (r_wait_cnt != '1)) begin
            r_wait_cnt <= r_wait_cnt + PERF_W'(1);
         end
      end
   end

   assign lu_stall_cnt = r_lu_stall_cnt;
   assign br_flush_cnt = r_br_flush_cnt;
   assign wait_cnt     = r_wait_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//   Directed bench for hazard_ctrl_unit. A behavioural model (consecutive
//   busy-cycle count, halted flag, sticky error) predicts the controls each
//   cycle; hand-computed literal patterns pin both the model and the DUT.
//   Output vector bit order: {pc_write, if_id_write, if_id_flush, id_ex_hold,
//   id_ex_flush, ex_mem_flush, mem_freeze, timeout_err}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;
   import core_pkg::*;

   localparam int REG_AW      = 5;
   localparam int MEM_TIMEOUT = 16;
   localparam int TMR_W       = 5;
   localparam int PERF_W      = 32;

   localparam logic [7:0] L_RST     = 8'b0010_1100;
   localparam logic [7:0] L_DEF     = 8'b1100_0000;
   localparam logic [7:0] L_STALL   = 8'b0000_1000;
   localparam logic [7:0] L_BR      = 8'b1110_1100;
   localparam logic [7:0] L_FRZ     = 8'b0001_0010;
   localparam logic [7:0] L_FRZ_ERR = 8'b0001_0011;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset = 1'b1;
   logic [REG_AW-1:0] id_rs = '0;
   logic [REG_AW-1:0] id_rt = '0;
   logic              id_uses_rt = 1'b0;
   logic              ex_mem_read = 1'b0;
   logic [REG_AW-1:0] ex_rt = '0;
   logic              mem_branch = 1'b0;
   logic              mem_busy = 1'b0;

   logic pc_write, if_id_write, if_id_flush, id_ex_hold;
   logic id_ex_flush, ex_mem_flush, mem_freeze, timeout_err;
   logic [1:0] dbg_state;
`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] lu_stall_cnt, br_flush_cnt, wait_cnt;
`endif

   hazard_ctrl_unit #(
      .REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(TMR_W), .PERF_W(PERF_W)
   ) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .mem_branch(mem_branch), .mem_busy(mem_busy),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_freeze(mem_freeze),
      .timeout_err(timeout_err), .dbg_state(dbg_state)
`ifdef HAZARD_PERF_EN
      , .lu_stall_cnt(lu_stall_cnt), .br_flush_cnt(br_flush_cnt), .wait_cnt(wait_cnt)
`endif
   );

   logic [7:0] dut_vec;
   assign dut_vec = {pc_write, if_id_write, if_id_flush, id_ex_hold,
                     id_ex_flush, ex_mem_flush, mem_freeze, timeout_err};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int   m_run  = 0;     // consecutive busy cycles seen so far
   logic m_halt = 1'b0;
   logic m_err  = 1'b0;
   int   m_lu = 0, m_br = 0, m_wait = 0;

   function automatic logic model_lu();
      return ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

   function automatic logic [7:0] model_out();
      if (reset)                    return L_RST;
      if (m_halt || mem_busy)       return {7'b0001_001, m_err};
      if (mem_branch)               return {7'b1110_110, m_err};
      if (model_lu())               return {7'b0000_100, m_err};
      return {7'b1100_000, m_err};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_run  <= 0;
         m_halt <= 1'b0;
         m_err  <= 1'b0;
         m_lu   <= 0;
         m_br   <= 0;
         m_wait <= 0;
      end else begin
         if (m_halt || mem_busy)  m_wait <= m_wait + 1;
         else if (mem_branch)     m_br   <= m_br + 1;
         else if (model_lu())     m_lu   <= m_lu + 1;
         if (!m_halt) begin
            if (mem_busy) begin
               m_run <= m_run + 1;
               if (m_run + 1 >= MEM_TIMEOUT) begin
                  m_halt <= 1'b1;
                  m_err  <= 1'b1;
               end
            end else begin
               m_run <= 0;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   // Entry: {has_literal, literal expected vector}; one per driven cycle.
   logic [8:0] exp_q[$];
   logic [8:0] sb_ent;
   logic [7:0] sb_model;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         sb_ent   = exp_q.pop_front();
         sb_model = model_out();
         chk("model_cmp", {24'd0, dut_vec}, {24'd0, sb_model});
         if (sb_ent[8]) begin
            chk("literal_dut", {24'd0, dut_vec}, {24'd0, sb_ent[7:0]});
            chk("literal_model", {24'd0, sb_model}, {24'd0, sb_ent[7:0]});
         end
`ifdef HAZARD_PERF_EN
         chk("lu_stall_cnt", lu_stall_cnt, m_lu);
         chk("br_flush_cnt", br_flush_cnt, m_br);
         chk("wait_cnt", wait_cnt, m_wait);
`endif
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic rst, input logic busy, input logic br,
                       input logic mrd, input logic [REG_AW-1:0] ert,
                       input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic urt, input logic lit_en, input logic [7:0] lit);
      @(posedge clk);
      #1;
      reset       = rst;
      mem_busy    = busy;
      mem_branch  = br;
      ex_mem_read = mrd;
      ex_rt       = ert;
      id_rs       = rs;
      id_rt       = rt;
      id_uses_rt  = urt;
      exp_q.push_back({lit_en, lit});
   endtask

   task automatic idle(input logic [7:0] lit);
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, lit);
   endtask

   // Raise reset partway through the current cycle and check the outputs
   // react before any clock edge.
   task automatic mid_cycle_reset(input string name);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk(name, {24'd0, dut_vec}, {24'd0, L_RST});
      chk({name, "_state"}, {30'd0, dbg_state}, {30'd0, HZ_RUN});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, L_RST);
      step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, L_RST);
      idle(L_DEF);

      // load-use on rs, then the load moves on
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b1, 1'b1, L_STALL);
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 5'd2, 1'b1, 1'b1, L_DEF);
      // load-use on rt
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b1, L_STALL);
      // rt match but rt not a source
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b1, L_DEF);
      // load to r0 never stalls
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, L_DEF);

      // branch beats load-use; branch alone
      step(1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 5'd2, 1'b1, 1'b1, L_BR);
      step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_BR);
      idle(L_DEF);

      // 3-cycle memory wait (busy beats branch/load-use), release services load-use
      step(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 5'd2, 1'b1, 1'b1, L_FRZ);
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_FRZ);
      step(1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b1, 1'b1, L_FRZ);
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b1, 1'b1, L_STALL);
      idle(L_DEF);

      // 1-cycle wait, release services a branch
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_FRZ);
      step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_BR);
      idle(L_DEF);

      // MEM_TIMEOUT-1 busy cycles: no error
      for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_FRZ);
      end
      idle(L_DEF);

      // MEM_TIMEOUT busy cycles: error, HALT, inputs ignored
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_FRZ);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_FRZ_ERR);
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b1, 1'b1, L_FRZ_ERR);
      idle(L_FRZ_ERR);
      @(negedge clk);
      #1;
      chk("halt_state", {30'd0, dbg_state}, {30'd0, HZ_HALT});

      // async reset out of HALT
      mid_cycle_reset("async_rst_halt");
      step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, L_RST);
      idle(L_DEF);

      // reset mid-wait
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_FRZ);
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_FRZ);
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_FRZ);
      mid_cycle_reset("async_rst_wait");
      step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_RST);
      idle(L_DEF);
      // a fresh wait after reset counts from zero
      for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, L_FRZ);
      end
      idle(L_DEF);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         chk("sb_drain", exp_q.size(), 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
